iter_mul_unit: RTL
==================

// Module: iter_mul_unit
// PURPOSE
//   Parametrised multi-cycle multiply/multiply-accumulate unit for the ARM core.
//   It replaces the single-cycle combinational MUL/MLA/MLS path in the ALU and adds UMULL (double-width product).
//   Uses a start/busy/done handshake so the hazard unit can stall Execute while an operation is in flight.
// PARAMETERS
//   WIDTH          32  operand width in bits; must be even and >= 8
//   BITS_PER_CYCLE 1   multiplier bits retired per MUL cycle; must divide WIDTH (1, 2, 4)
// PORTS
//   clk       in   1          rising-edge clock
//   reset     in   1          synchronous, active-high
//   Start     in   1          request; accepted only when Busy==0 and Flush==0
//   Op        in   2          00 MUL, 01 MLA, 10 MLS, 11 UMULL; sampled with Start
//   SrcA      in   WIDTH      multiplicand; sampled with Start
//   SrcB      in   WIDTH      multiplier; sampled with Start
//   SrcC      in   WIDTH      accumulate operand (MLA/MLS only); sampled with Start
//   Flush     in   1          synchronous abort of an in-flight operation
//   Busy      out  1          high in MUL and ACC states
//   Done      out  1          one-cycle pulse; ResultLo/ResultHi/Flags valid in this cycle
//   ResultLo  out  WIDTH      low result word
//   ResultHi  out  WIDTH      high word (UMULL); 0 for all other ops
//   Flags     out  2          {N,Z} of the result
// BEHAVIOUR
//   Reset: state=IDLE; Busy=0, Done=0, ResultLo=0, ResultHi=0, Flags=0; operand registers cleared.
//   States:
//     IDLE -> MUL on accepted Start.
//     MUL: add BITS_PER_CYCLE partial products per cycle into a 2*WIDTH accumulator, shifting the multiplier right.
//       After N=WIDTH/BITS_PER_CYCLE cycles -> ACC.
//     ACC (1 cycle): MLA adds SrcC; MLS subtracts the product from SrcC; MUL/UMULL pass through. Then -> DONE.
//     DONE: Done=1 and Busy=0 for exactly one cycle, then -> IDLE.
//       A Start in DONE is accepted (back-to-back) and goes directly to MUL.
//   Latency: Start sampled in cycle 0 -> Done high in cycle N+2 (34 for the defaults).
//   Arithmetic: unsigned product P = A*B (2*WIDTH bits).
//     MUL:   Lo = P mod 2^WIDTH
//     MLA:   Lo = (C + P) mod 2^WIDTH
//     MLS:   Lo = (C - P) mod 2^WIDTH
//     UMULL: {Hi,Lo} = P
//   Flags: N = MSB of the result (Hi[WIDTH-1] for UMULL, otherwise Lo[WIDTH-1]).
//     Z = 1 iff all result bits are zero (Hi and Lo for UMULL; Lo only otherwise).
//   Outputs: ResultLo/ResultHi/Flags update only on entry to DONE and hold until the next DONE. Done never asserts twice for one Start.
//   Start while Busy: ignored, with no effect on the current operation.
//   Flush: in MUL or ACC -> IDLE next cycle; Done not asserted; outputs keep their previous values.
//     Flush in IDLE/DONE: a coincident Start is dropped; flush wins.
//   reset has priority over Flush and Start in every state, including mid-operation.
//   Operand inputs may change freely after the Start cycle; only registered copies are used.
// CONFIGURATION
//   MUL_EARLY_TERM_EN defined: MUL exits to ACC as soon as the remaining multiplier bits are all zero.
//     MUL lasts max(1, ceil((msb_index(B)+1)/BITS_PER_CYCLE)) cycles. B==0 gives Done in cycle 3.
//   MUL_EARLY_TERM_EN undefined: MUL always lasts exactly N cycles (fixed latency).
//   Results are identical in both builds.
// STRUCTURE
//   Shared package mul_pkg holds:
//     op encodings MUL_OP_MUL/MLA/MLS/UMULL
//     state encodings S_IDLE, S_MUL, S_ACC, S_DONE
//     a function giving the iteration count from WIDTH and BITS_PER_CYCLE
//   Sub-module mul_step is combinational: it takes the accumulator, multiplicand and BITS_PER_CYCLE multiplier bits and returns the next accumulator.
//   The FSM, operand registers and output registers live in iter_mul_unit.
// TESTING
//   1. MUL 7*6, defaults -> Done in cycle 34; Lo=42, Hi=0, Flags=00; Busy high in cycles 1-33.
//   2. UMULL 0xFFFFFFFF*0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001, N=1, Z=0.
//   3. MLS C=10, A=3, B=4 -> Lo=0xFFFFFFFE, N=1; MLA C=5, A=0, B=9 -> Lo=5, Z=0.
//   4. Flush in cycle 10 of MUL -> IDLE in cycle 11; no Done; outputs keep the prior result.
//      Start during Busy -> ignored.
//   5. Back-to-back: Start held high in the DONE cycle -> second op accepted; second Done 34 cycles later.
//      reset mid-MUL -> all outputs 0 next cycle.
//   6. MUL_EARLY_TERM_EN, BITS_PER_CYCLE=2: B=0 -> Done in cycle 3; B=3 -> Done in cycle 3; B=0x80000000 -> Done in cycle 18.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiply unit: op codes, FSM states and the
// iteration-count helper.
package mul_pkg;

    localparam logic [1:0] MUL_OP_MUL   = 2'b00;
    localparam logic [1:0] MUL_OP_MLA   = 2'b01;
    localparam logic [1:0] MUL_OP_MLS   = 2'b10;
    localparam logic [1:0] MUL_OP_UMULL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_ACC  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    function automatic int unsigned mul_iters(input int unsigned width, input int unsigned bpc);
        return width / bpc;
    endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-add iteration: adds BITS_PER_CYCLE partial products of the (pre-shifted)
// multiplicand into the double-width accumulator.
module mul_step #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic [2*WIDTH-1:0]        acc,
    input  logic [2*WIDTH-1:0]        mcand,
    input  logic [BITS_PER_CYCLE-1:0] bits,
    output logic [2*WIDTH-1:0]        acc_next
);

    always_comb begin
        acc_next = acc;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            if (bits[i]) begin
                acc_next = acc_next + (mcand << i);
            end
        end
    end

endmodule

// File: rtl/iter_mul_unit.sv
// Multi-cycle MUL/MLA/MLS/UMULL unit with start/busy/done handshake.
// Define MUL_EARLY_TERM_EN to end the MUL phase once the remaining multiplier bits are zero.
module iter_mul_unit
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [WIDTH-1:0] SrcC,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi,
    output logic [1:0]       Flags
);

    localparam int unsigned ITERS = mul_iters(WIDTH, BITS_PER_CYCLE);
    localparam int unsigned CW    = (ITERS > 1) ? $clog2(ITERS) : 1;

    state_t               state_q, state_d;
    logic                 load;
    logic [1:0]           op_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [WIDTH-1:0]     srcc_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CW-1:0]        cnt_q;
    logic [WIDTH-1:0]     res_lo_q, res_hi_q;
    logic [1:0]           flags_q;

    logic [2*WIDTH-1:0]   acc_step;
    logic [WIDTH-1:0]     mplier_next;
    logic                 last_iter;
    logic                 mul_exit;
    logic [WIDTH-1:0]     fin_lo, fin_hi;
    logic [1:0]           fin_flags;

    mul_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .acc      (acc_q),
        .mcand    (mcand_q),
        .bits     (mplier_q[BITS_PER_CYCLE-1:0]),
        .acc_next (acc_step)
    );

    assign mplier_next = mplier_q >> BITS_PER_CYCLE;
    assign last_iter   = (cnt_q == CW'(ITERS - 1));

`ifdef MUL_EARLY_TERM_EN
    assign mul_exit = last_iter || (mplier_next == '0);
`else
    assign mul_exit = last_iter;
`endif

    // Final result formed in ACC from the completed product.
    always_comb begin
        fin_hi = '0;
        unique case (op_q)
            MUL_OP_MLA:   fin_lo = srcc_q + acc_q[WIDTH-1:0];
            MUL_OP_MLS:   fin_lo = srcc_q - acc_q[WIDTH-1:0];
            MUL_OP_UMULL: begin
                fin_lo = acc_q[WIDTH-1:0];
                fin_hi = acc_q[2*WIDTH-1:WIDTH];
            end
            default:      fin_lo = acc_q[WIDTH-1:0];
        endcase
        if (op_q == MUL_OP_UMULL) begin
            fin_flags = {fin_hi[WIDTH-1], ~|{fin_hi, fin_lo}};
        end else begin
            fin_flags = {fin_lo[WIDTH-1], ~|fin_lo};
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (Start && !Flush) begin
                    state_d = S_MUL;
                    load    = 1'b1;
                end
            end
            S_MUL: begin
                if (Flush)         state_d = S_IDLE;
                else if (mul_exit) state_d = S_ACC;
            end
            S_ACC: begin
                state_d = Flush ? S_IDLE : S_DONE;
            end
            default: begin
                if (Start && !Flush) begin
                    state_d = S_MUL;
                    load    = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            srcc_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                op_q     <= Op;
                mcand_q  <= {{WIDTH{1'b0}}, SrcA};
                mplier_q <= SrcB;
                srcc_q   <= SrcC;
                acc_q    <= '0;
                cnt_q    <= '0;
            end else if (state_q == S_MUL) begin
                acc_q    <= acc_step;
                mcand_q  <= mcand_q << BITS_PER_CYCLE;
                mplier_q <= mplier_next;
                cnt_q    <= cnt_q + CW'(1);
            end
            if (state_q == S_ACC && state_d == S_DONE) begin
                res_lo_q <= fin_lo;
                res_hi_q <= fin_hi;
                flags_q  <= fin_flags;
            end
        end
    end

    assign Busy     = (state_q == S_MUL) || (state_q == S_ACC);
    assign Done     = (state_q == S_DONE);
    assign ResultLo = res_lo_q;
    assign ResultHi = res_hi_q;
    assign Flags    = flags_q;

endmodule
